// File: rtl/siteswap_scheduler.sv
// siteswap_scheduler
//
// Turns a latched siteswap pattern into a stream of throws. Each new_beat
// reads the next pattern entry, decides which ball leaves which hand at what
// height, and keeps per-ball flight bookkeeping for the renderer.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   new_beat          single-cycle beat strobe
//   pattern_in        throw heights, entry 0 in bits [2:0]
//   pattern_length    number of valid entries (1..7)
//   num_balls_in      ball count
//   pattern_valid_in  level; a rising edge loads pattern/length/ball count
//   throw_valid_out   one-cycle pulse on a beat that produced a throw
//   throw_ball_out    id of the thrown ball
//   throw_height_out  height of the throw
//   throw_hand_out    throwing hand (0 = right, 1 = left)
//   ball_active_out   per ball: has been introduced
//   ball_height_out   per ball: height of its current flight
//   ball_elapsed_out  per ball: beats since its last throw (saturates at 7)
//   ball_hand_out     per ball: hand that threw it
//   running_out       high while processing beats
//   error_out         high after an invalid load or an impossible beat
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | nothing loaded since reset; beats ignored
// RUN    | pattern loaded; every new_beat advances the juggle
// ERROR  | bad load, collision, starvation or a landing on a 0 beat;
//        | outputs frozen until the next load or reset

module siteswap_scheduler #(
    parameter int MAX_LEN    = 7,
    parameter int MAX_BALLS  = 7,
    parameter int MAX_HEIGHT = 7
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          new_beat,
    input  logic [MAX_LEN-1:0][2:0]       pattern_in,
    input  logic [2:0]                    pattern_length,
    input  logic [2:0]                    num_balls_in,
    input  logic                          pattern_valid_in,
    output logic                          throw_valid_out,
    output logic [2:0]                    throw_ball_out,
    output logic [2:0]                    throw_height_out,
    output logic                          throw_hand_out,
    output logic [MAX_BALLS-1:0]          ball_active_out,
    output logic [MAX_BALLS-1:0][2:0]     ball_height_out,
    output logic [MAX_BALLS-1:0][2:0]     ball_elapsed_out,
    output logic [MAX_BALLS-1:0]          ball_hand_out,
    output logic                          running_out,
    output logic                          error_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                        pv_q;
    logic                        load;

    logic [MAX_LEN-1:0][2:0]     pat_q, pat_d;
    logic [2:0]                  len_q, len_d;
    logic [2:0]                  nb_q, nb_d;

    // Landing queue: slot k holds the ball that comes down k beats from now.
    logic [MAX_HEIGHT:0]         q_vld_q, q_vld_d;
    logic [MAX_HEIGHT:0][2:0]    q_id_q, q_id_d;

    logic [2:0]                  idx_q, idx_d;
    logic                        parity_q, parity_d;
    logic [2:0]                  launched_q, launched_d;

    logic                        tv_q, tv_d;
    logic [2:0]                  tb_q, tb_d;
    logic [2:0]                  th_q, th_d;
    logic                        thd_q, thd_d;

    logic [MAX_BALLS-1:0]        act_q, act_d;
    logic [MAX_BALLS-1:0][2:0]   bh_q, bh_d;
    logic [MAX_BALLS-1:0][2:0]   be_q, be_d;
    logic [MAX_BALLS-1:0]        bhd_q, bhd_d;

    logic [2:0]                  h;
    logic                        landing;
    logic                        collide;
    logic                        starve;
    logic                        beat_err;
    logic [2:0]                  ball_sel;

    // Only a low-to-high transition of the level loads a pattern.
    assign load = pattern_valid_in & ~pv_q;

    assign h        = pat_q[idx_q];
    assign landing  = q_vld_q[0];
    assign collide  = (h != 3'd0) && q_vld_q[h];
    assign starve   = (h != 3'd0) && !landing && (launched_q == nb_q);
    assign beat_err = ((h == 3'd0) && landing) || starve || collide;

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        nb_d       = nb_q;
        q_vld_d    = q_vld_q;
        q_id_d     = q_id_q;
        idx_d      = idx_q;
        parity_d   = parity_q;
        launched_d = launched_q;
        tv_d       = 1'b0;
        tb_d       = tb_q;
        th_d       = th_q;
        thd_d      = thd_q;
        act_d      = act_q;
        bh_d       = bh_q;
        be_d       = be_q;
        bhd_d      = bhd_q;
        ball_sel   = landing ? q_id_q[0] : launched_q;

        if (load) begin
            // A load wins over a coincident beat; that beat is simply lost.
            pat_d      = pattern_in;
            len_d      = pattern_length;
            nb_d       = num_balls_in;
            q_vld_d    = '0;
            q_id_d     = '0;
            idx_d      = 3'd0;
            parity_d   = 1'b0;
            launched_d = 3'd0;
            tb_d       = 3'd0;
            th_d       = 3'd0;
            thd_d      = 1'b0;
            act_d      = '0;
            bh_d       = '0;
            be_d       = '0;
            bhd_d      = '0;
            if ((pattern_length == 3'd0) || (num_balls_in == 3'd0)) begin
                state_d = ST_ERROR;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (new_beat) begin
                        if (beat_err) begin
                            // Freeze everything; only the state moves.
                            state_d = ST_ERROR;
                        end else begin
                            for (int k = 0; k < MAX_HEIGHT; k++) begin
                                q_vld_d[k] = q_vld_q[k+1];
                                q_id_d[k]  = q_id_q[k+1];
                            end
                            q_vld_d[MAX_HEIGHT] = 1'b0;
                            q_id_d[MAX_HEIGHT]  = 3'd0;

                            for (int b = 0; b < MAX_BALLS; b++) begin
                                if (act_q[b] && (be_q[b] != 3'd7)) begin
                                    be_d[b] = be_q[b] + 3'd1;
                                end
                            end

                            if (h != 3'd0) begin
                                if (!landing) begin
                                    launched_d = launched_q + 3'd1;
                                end
                                // Slot h before the shift is slot h-1 after it.
                                q_vld_d[h - 3'd1] = 1'b1;
                                q_id_d[h - 3'd1]  = ball_sel;
                                act_d[ball_sel]   = 1'b1;
                                bh_d[ball_sel]    = h;
                                be_d[ball_sel]    = 3'd0;
                                bhd_d[ball_sel]   = parity_q;
                                tv_d              = 1'b1;
                                tb_d              = ball_sel;
                                th_d              = h;
                                thd_d             = parity_q;
                            end

                            parity_d = ~parity_q;
                            idx_d    = (idx_q + 3'd1 == len_q) ? 3'd0 : idx_q + 3'd1;
                        end
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // Track the input through reset so a level still high afterwards
            // is not mistaken for a fresh rising edge.
            pv_q       <= pattern_valid_in;
            state_q    <= ST_IDLE;
            pat_q      <= '0;
            len_q      <= 3'd0;
            nb_q       <= 3'd0;
            q_vld_q    <= '0;
            q_id_q     <= '0;
            idx_q      <= 3'd0;
            parity_q   <= 1'b0;
            launched_q <= 3'd0;
            tv_q       <= 1'b0;
            tb_q       <= 3'd0;
            th_q       <= 3'd0;
            thd_q      <= 1'b0;
            act_q      <= '0;
            bh_q       <= '0;
            be_q       <= '0;
            bhd_q      <= '0;
        end else begin
            pv_q       <= pattern_valid_in;
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            nb_q       <= nb_d;
            q_vld_q    <= q_vld_d;
            q_id_q     <= q_id_d;
            idx_q      <= idx_d;
            parity_q   <= parity_d;
            launched_q <= launched_d;
            tv_q       <= tv_d;
            tb_q       <= tb_d;
            th_q       <= th_d;
            thd_q      <= thd_d;
            act_q      <= act_d;
            bh_q       <= bh_d;
            be_q       <= be_d;
            bhd_q      <= bhd_d;
        end
    end

    assign throw_valid_out  = tv_q;
    assign throw_ball_out   = tb_q;
    assign throw_height_out = th_q;
    assign throw_hand_out   = thd_q;
    assign ball_active_out  = act_q;
    assign ball_height_out  = bh_q;
    assign ball_elapsed_out = be_q;
    assign ball_hand_out    = bhd_q;
    assign running_out      = (state_q == ST_RUN);
    assign error_out        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_siteswap_scheduler.sv
module tb_siteswap_scheduler;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             new_beat;
    logic [6:0][2:0]  pattern_in;
    logic [2:0]       pattern_length;
    logic [2:0]       num_balls_in;
    logic             pattern_valid_in;
    logic             throw_valid_out;
    logic [2:0]       throw_ball_out;
    logic [2:0]       throw_height_out;
    logic             throw_hand_out;
    logic [6:0]       ball_active_out;
    logic [6:0][2:0]  ball_height_out;
    logic [6:0][2:0]  ball_elapsed_out;
    logic [6:0]       ball_hand_out;
    logic             running_out;
    logic             error_out;

    siteswap_scheduler dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .new_beat         (new_beat),
        .pattern_in       (pattern_in),
        .pattern_length   (pattern_length),
        .num_balls_in     (num_balls_in),
        .pattern_valid_in (pattern_valid_in),
        .throw_valid_out  (throw_valid_out),
        .throw_ball_out   (throw_ball_out),
        .throw_height_out (throw_height_out),
        .throw_hand_out   (throw_hand_out),
        .ball_active_out  (ball_active_out),
        .ball_height_out  (ball_height_out),
        .ball_elapsed_out (ball_elapsed_out),
        .ball_hand_out    (ball_hand_out),
        .running_out      (running_out),
        .error_out        (error_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each ball remembers the absolute beat it lands on.
    int m_st;            // 0 idle, 1 run, 2 error
    int m_pat[7];
    int m_len, m_nb, m_idx, m_par, m_launched, m_t;
    int m_act[7], m_land[7], m_h[7], m_el[7], m_hd[7];
    int m_tv, m_tb, m_th, m_thd;
    bit pv_prev;

    int exp_casc[6]  = '{0, 1, 2, 0, 1, 2};
    int exp_441[9]   = '{0, 1, 2, 2, 0, 1, 1, 2, 0};
    int exp_40v[5]   = '{1, 0, 1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_idx = 0; m_par = 0; m_launched = 0; m_t = 0;
        m_tv = 0; m_tb = 0; m_th = 0; m_thd = 0;
        for (int b = 0; b < 7; b++) begin
            m_act[b] = 0; m_land[b] = 0; m_h[b] = 0; m_el[b] = 0; m_hd[b] = 0;
        end
    endtask

    task automatic model_load();
        model_clear();
        for (int i = 0; i < 7; i++) m_pat[i] = int'(pattern_in[i]);
        m_len = int'(pattern_length);
        m_nb  = int'(num_balls_in);
        m_st  = (m_len == 0 || m_nb == 0) ? 2 : 1;
    endtask

    task automatic model_beat();
        int hh, lander, coll, thrown;
        m_tv = 0;
        if (m_st != 1) return;
        hh = m_pat[m_idx];
        lander = -1;
        coll = 0;
        for (int b = 0; b < 7; b++) begin
            if (m_act[b] != 0 && m_land[b] == m_t) lander = b;
            if (m_act[b] != 0 && hh > 0 && m_land[b] == m_t + hh) coll = 1;
        end
        if ((hh == 0 && lander >= 0) || (hh > 0 && lander < 0 && m_launched >= m_nb) || coll != 0) begin
            m_st = 2;
            return;
        end
        for (int b = 0; b < 7; b++)
            if (m_act[b] != 0 && m_el[b] < 7) m_el[b]++;
        if (hh > 0) begin
            if (lander >= 0) thrown = lander;
            else begin
                thrown = m_launched;
                m_launched++;
            end
            m_act[thrown] = 1;
            m_land[thrown] = m_t + hh;
            m_h[thrown] = hh;
            m_el[thrown] = 0;
            m_hd[thrown] = m_par;
            m_tv = 1; m_tb = thrown; m_th = hh; m_thd = m_par;
        end
        m_t++;
        m_par ^= 1;
        m_idx = (m_idx + 1 == m_len) ? 0 : m_idx + 1;
    endtask

    task automatic check_all(input string tag);
        logic [6:0]  ea, ehd;
        logic [20:0] eh, ee;
        for (int b = 0; b < 7; b++) begin
            ea[b]          = m_act[b][0];
            ehd[b]         = m_hd[b][0];
            eh[b*3 +: 3]   = m_h[b][2:0];
            ee[b*3 +: 3]   = m_el[b][2:0];
        end
        chk({tag, ".tv"}, 32'(throw_valid_out), 32'(m_tv));
        if (m_tv != 0) begin
            chk({tag, ".tball"}, 32'(throw_ball_out), 32'(m_tb));
            chk({tag, ".theight"}, 32'(throw_height_out), 32'(m_th));
            chk({tag, ".thand"}, 32'(throw_hand_out), 32'(m_thd));
        end
        chk({tag, ".active"}, 32'(ball_active_out), 32'(ea));
        chk({tag, ".bheight"}, 32'(ball_height_out), 32'(eh));
        chk({tag, ".belapsed"}, 32'(ball_elapsed_out), 32'(ee));
        chk({tag, ".bhand"}, 32'(ball_hand_out), 32'(ehd));
        chk({tag, ".running"}, 32'(running_out), 32'(m_st == 1));
        chk({tag, ".error"}, 32'(error_out), 32'(m_st == 2));
    endtask

    // One clock: drive inputs, advance model, check all outputs.
    task automatic cyc(input string tag, input bit rst, input bit beat, input bit pv);
        rst_in = rst;
        new_beat = beat;
        pattern_valid_in = pv;
        @(posedge clk_in);
        #1;
        if (rst) begin
            model_clear();
            m_st = 0;
            for (int i = 0; i < 7; i++) m_pat[i] = 0;
            m_len = 0; m_nb = 0;
        end else if (pv && !pv_prev) begin
            model_load();
            m_tv = 0;
        end else if (beat) begin
            model_beat();
        end else begin
            m_tv = 0;
        end
        pv_prev = pv;
        check_all(tag);
    endtask

    task automatic set_pat(input int e0, input int e1, input int e2, input int len, input int nb);
        pattern_in = '0;
        pattern_in[0] = 3'(e0);
        pattern_in[1] = 3'(e1);
        pattern_in[2] = 3'(e2);
        pattern_length = 3'(len);
        num_balls_in = 3'(nb);
    endtask

    initial begin
        rst_in = 1'b1;
        new_beat = 1'b0;
        pattern_valid_in = 1'b0;
        pattern_in = '0;
        pattern_length = 3'd0;
        num_balls_in = 3'd0;
        pv_prev = 1'b0;
        m_st = 0; m_len = 0; m_nb = 0;
        for (int i = 0; i < 7; i++) m_pat[i] = 0;
        model_clear();

        cyc("reset", 1, 0, 0);
        cyc("reset", 1, 1, 0);
        chk("reset.running", 32'(running_out), 32'd0);
        cyc("idle_beat", 0, 1, 0);

        // Cascade "3", 3 balls
        set_pat(3, 0, 0, 1, 3);
        cyc("casc_load", 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc("casc", 0, 1, 1);
            chk("casc.id", 32'(throw_ball_out), 32'(exp_casc[i]));
            chk("casc.hand", 32'(throw_hand_out), 32'(i % 2));
            chk("casc.h", 32'(throw_height_out), 32'd3);
            cyc("casc_gap", 0, 0, 1);
        end

        // Excited "441", 3 balls
        cyc("drop", 0, 0, 0);
        set_pat(4, 4, 1, 3, 3);
        cyc("441_load", 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            cyc("441", 0, 1, 1);
            chk("441.id", 32'(throw_ball_out), 32'(exp_441[i]));
            chk("441.h", 32'(throw_height_out), 32'((i % 3 == 2) ? 1 : 4));
            chk("441.err", 32'(error_out), 32'd0);
        end

        // Gap "40", 2 balls
        cyc("drop", 0, 0, 0);
        set_pat(4, 0, 0, 2, 2);
        cyc("40_load", 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc("40", 0, 1, 1);
            chk("40.tv", 32'(throw_valid_out), 32'(exp_40v[i]));
        end

        // Collision "43", 3 balls
        cyc("drop", 0, 0, 0);
        set_pat(4, 3, 0, 2, 3);
        cyc("43_load", 0, 0, 1);
        cyc("43_b0", 0, 1, 1);
        chk("43.b0h", 32'(throw_height_out), 32'd4);
        cyc("43_b1", 0, 1, 1);
        chk("43.err", 32'(error_out), 32'd1);
        chk("43.tv", 32'(throw_valid_out), 32'd0);
        cyc("43_b2", 0, 1, 1);
        cyc("43_b3", 0, 1, 1);

        // Reload "51" during a "3" run, load edge coincident with a beat
        cyc("drop", 0, 0, 0);
        set_pat(3, 0, 0, 1, 3);
        cyc("r_load", 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc("r3", 0, 1, 1);
        cyc("r_drop", 0, 0, 0);
        set_pat(5, 1, 0, 2, 3);
        cyc("r_load51", 0, 1, 1);
        chk("reload.active", 32'(ball_active_out), 32'd0);
        cyc("r51_b0", 0, 1, 1);
        chk("reload.id", 32'(throw_ball_out), 32'd0);
        chk("reload.h", 32'(throw_height_out), 32'd5);
        for (int i = 0; i < 4; i++) cyc("r51", 0, 1, 1);

        // Held level for 20 beats, then reset mid-flight with level still high
        cyc("drop", 0, 0, 0);
        set_pat(3, 0, 0, 1, 3);
        cyc("held_load", 0, 0, 1);
        for (int i = 0; i < 20; i++) cyc("held", 0, 1, 1);
        cyc("held_rst", 1, 0, 1);
        chk("held_rst.active", 32'(ball_active_out), 32'd0);
        chk("held_rst.running", 32'(running_out), 32'd0);
        for (int i = 0; i < 3; i++) cyc("post_rst", 0, 1, 1);
        chk("post_rst.running", 32'(running_out), 32'd0);
        cyc("post_drop", 0, 0, 0);
        cyc("post_load", 0, 0, 1);
        chk("post_load.running", 32'(running_out), 32'd1);
        for (int i = 0; i < 4; i++) cyc("post", 0, 1, 1);

        // Randomized patterns against the model
        for (int t = 0; t < 40; t++) begin
            cyc("rnd_drop", 0, 0, 0);
            pattern_in = '0;
            for (int i = 0; i < 7; i++)
                pattern_in[i] = 3'((t % 2 == 0) ? $urandom_range(1, 7) : $urandom_range(0, 7));
            pattern_length = 3'((t % 8 == 3) ? 0 : $urandom_range(1, 7));
            num_balls_in = 3'((t % 11 == 7) ? 0 : $urandom_range(1, 7));
            cyc("rnd_load", 0, 1'($urandom_range(0, 1)), 1);
            for (int c = 0; c < 16; c++) begin
                if (t % 10 == 5 && c == 8) cyc("rnd_rst", 1, 0, 1);
                else cyc("rnd", 0, 1'($urandom_range(0, 1)), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
